// File: rtl/lsu_bus_if.sv
// Load/store unit for the MEM stage: turns decoder MemRead/MemWrite/RW_type into one
// req/ack data-bus transaction per instruction, with byte steering and load extension.
//
// state | meaning
// IDLE  | waiting for a load/store; misaligned accesses are flagged here and never issued
// BUSY  | bus_req held with stable bus outputs until bus_ack or timeout
// DONE  | one-cycle done pulse; pipeline advances, control inputs ignored
module lsu_bus_if #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  rw_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    rw_q;
    logic [1:0]    lane_q;

    logic        is_byte, is_half, is_word;
    logic        mis_cond, req_any, access;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ext;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Undefined width codes fall through to word.
    always_comb begin
        is_byte = (rw_type == 3'b000) || (rw_type == 3'b100);
        is_half = (rw_type == 3'b001) || (rw_type == 3'b101);
        is_word = !is_byte && !is_half;
    end

    assign req_any    = mem_read | mem_write;
    assign mis_cond   = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign misaligned = (state == IDLE) && req_any && mis_cond;
    assign access     = (state == IDLE) && req_any && !mis_cond;
    assign stall      = access || (state == BUSY);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        if (is_byte) begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
        end
    end

    // Extraction uses the width and lane latched at request time, not the live inputs.
    always_comb begin
        sel_b = bus_rdata[8*lane_q +: 8];
        sel_h = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (rw_q)
            3'b000:  ext = {{24{sel_b[7]}}, sel_b};
            3'b100:  ext = {24'h0, sel_b};
            3'b001:  ext = {{16{sel_h[15]}}, sel_h};
            3'b101:  ext = {16'h0, sel_h};
            default: ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= '0;
            lane_q    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            load_data <= '0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (access) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= mem_write ? wdata_next : 32'h0;
                        rw_q      <= rw_type;
                        lane_q    <= addr[1:0];
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        load_data <= bus_we ? 32'h0 : ext;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if ((TIMEOUT != 0) && (cnt == TC)) begin
                        load_data <= '0;
                        bus_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store execution unit. It consumes the MemRead, MemWrite and RW_type control signals produced by the main decoder, and turns them into transactions on a word-wide data-memory bus using a req/ack handshake.
- It performs byte-lane steering and byte enables for stores, and extraction plus sign/zero extension for loads.
- It stalls the pipeline until the bus responds, and flags misaligned accesses and bus timeouts.
- It sits in the MEM stage, between the pipeline register and the data memory / peripheral interconnect.

Parameters:
TIMEOUT, 16, max cycles in BUSY without bus_ack before aborting with bus_err; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
mem_read  input  1  load request (from decoder MemRead)
mem_write  input  1  store request (from decoder MemWrite); wins if both are asserted
rw_type  input  3  access width: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; other codes are treated as word
addr  input  32  effective byte address
wdata  input  32  store data (rs2)
load_data  output  32  extended load result; valid while done=1
stall  output  1  holds pipeline; combinational
done  output  1  one-cycle pulse; access complete
misaligned  output  1  combinational; access rejected, no bus cycle
bus_err  output  1  valid with done; timeout occurred
bus_req  output  1  registered request
bus_we  output  1  1 = write
bus_addr  output  32  {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  read word, sampled at the edge where bus_ack=1
bus_ack  input  1  completion from memory

Behaviour:
- Reset values: state IDLE; timeout counter 0; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, done=0, bus_err=0.
- Reset asserted mid-transaction: bus_req drops at that edge, no done pulse, and any late bus_ack is ignored.
- States: IDLE, BUSY, DONE.
- Access = (mem_read | mem_write) & ~misaligned.
- misaligned definition:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0.
  - It is asserted only in IDLE, with no bus cycle and stall=0. The pipeline advances; trap handling is external.
- IDLE:
  - If Access is true: stall=1 this cycle.
  - At the edge, latch bus_we, bus_addr, bus_be, bus_wdata, rw_type and addr[1:0]; set bus_req=1; go to BUSY.
- BUSY:
  - stall=1; bus outputs held stable; counter increments every cycle.
  - When bus_ack=1 at an edge: capture the extended bus_rdata into load_data (stores leave load_data=0), bus_req=0, go to DONE.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: bus_req=0, bus_err=1, load_data=0, go to DONE.
  - bus_ack outside BUSY is ignored.
- DONE:
  - done=1 and stall=0 for exactly one cycle; the pipeline advances at this edge.
  - Go to IDLE with counter cleared and bus_err cleared.
  - Control inputs are not re-examined in DONE, so one instruction produces exactly one transaction.
- Minimum latency: a zero-wait ack gives request cycle + 1 BUSY cycle + DONE, i.e. stall is high for 2 cycles.
- Store steering (lane = addr[1:0]):
  - byte: bus_wdata = {4{wdata[7:0]}}, bus_be = 4'b0001 << lane.
  - half: bus_wdata = {2{wdata[15:0]}}, bus_be = addr[1] ? 1100 : 0011.
  - word: bus_wdata = wdata, bus_be = 1111.
- Loads: bus_be reflects the access width as above, and bus_wdata=0.
- Load extraction:
  - byte: select byte[lane]; code 000 sign-extends from bit 7, code 100 zero-extends.
  - half: select half[addr[1]]; code 001 sign-extends from bit 15, code 101 zero-extends.
  - word: passes through unchanged.

Test Plan:
- Store word: addr=0x100, wdata=0xDEADBEEF, rw=010, ack 1 cycle after req → bus_we=1, bus_addr=0x100, bus_be=1111, bus_wdata=0xDEADBEEF; stall high 2 cycles; done for 1 cycle.
- Byte loads at addr=0x203 with bus_rdata=0x80FF7F01, ack after 3 wait cycles:
  - rw=000 → load_data=0xFFFFFF80.
  - rw=100 → load_data=0x00000080.
  - stall high 5 cycles.
- Store half at addr=0x2 with wdata=0x1234ABCD, rw=001 → bus_be=1100, bus_wdata=0xABCDABCD.
- Misaligned: lw at 0x102, then sh at 0x101 → misaligned=1, stall=0, bus_req never asserts.
- Timeout: TIMEOUT=4, load with no ack → bus_req high 4 cycles then drops; done=1, bus_err=1, load_data=0; the next access starts cleanly.
- Reset mid-BUSY: assert rst 2 cycles into BUSY, then ack 1 cycle later → bus_req=0 after the reset edge, no done, state IDLE; and with mem_read=mem_write=1 → a write is issued.
